// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3
// size/sign codes, FSM state encoding and a direction-aware legality check.
package riscv_lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

   function automatic logic f3_legal(input logic we,
                                     input logic [2:0] f3);
      if (we)
         return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data memory: synchronous byte-write-enable write,
// asynchronous read. Ports: clk, we[3:0] per byte lane, addr (word index),
// wdata (lane-aligned), rdata (word at addr). Contents are never reset.
module dmem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = 8
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i])
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit with a fixed-latency response handshake.
// Ports: clk, reset (async, active-high); request req_valid/req_ready,
// req_we, req_funct3, req_addr, req_wdata; response rsp_valid/rsp_ready,
// rsp_rdata (extended load data), rsp_err (request rejected).
module load_store_unit
   import riscv_lsu_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int MEM_LAT     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(MEM_LAT + 1);

   lsu_state_e  state, state_nxt;
   logic [CW-1:0] cnt;
   logic        a_we;
   logic [2:0]  a_f3;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        accept;
   logic        done;
   logic        misal;
   logic        oor;
   logic        err;
   logic [3:0]  be;
   logic [3:0]  mem_we;
   logic [31:0] wdat;
   logic [31:0] rd_word;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] ld_val;

   assign accept = req_valid && req_ready;
   // Counter holds the cycles still to wait; the edge seen with 1 ends BUSY.
   assign done   = (state == ST_BUSY) && (cnt == CW'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (req_valid) state_nxt = ST_BUSY;
         ST_BUSY: if (done)      state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state)
         ST_IDLE: req_ready = 1'b1;
         ST_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         a_we    <= 1'b0;
         a_f3    <= '0;
         a_addr  <= '0;
         a_wdata <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            cnt     <= CW'(MEM_LAT);
            a_we    <= req_we;
            a_f3    <= req_funct3;
            a_addr  <= req_addr;
            a_wdata <= req_wdata;
         end else if (state == ST_BUSY) begin
            cnt <= cnt - CW'(1);
         end
         if (done) begin
            err_q   <= err;
            rdata_q <= (err || a_we) ? '0 : ld_val;
         end
      end
   end

   assign misal = ((a_f3[1:0] == 2'b01) && a_addr[0]) ||
                  ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
   assign oor   = (a_addr >> 2) >= 32'(DEPTH_WORDS);
   assign err   = !f3_legal(a_we, a_f3) || misal || oor;

   // Store data is replicated across lanes; byte enables pick the lane.
   always_comb begin
      be   = '0;
      wdat = a_wdata;
      unique case (a_f3[1:0])
         2'b00: begin
            be   = 4'b0001 << a_addr[1:0];
            wdat = {4{a_wdata[7:0]}};
         end
         2'b01: begin
            be   = a_addr[1] ? 4'b1100 : 4'b0011;
            wdat = {2{a_wdata[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = '0;
      endcase
   end

   assign mem_we = (done && a_we && !err) ? be : 4'b0000;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (a_addr[AW+1:2]),
      .wdata (wdat),
      .rdata (rd_word)
   );

   assign byte_v = rd_word[8*a_addr[1:0] +: 8];
   assign half_v = a_addr[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      ld_val = '0;
      unique case (1'b1)
         (a_f3 == F3_LB):  ld_val = {{24{byte_v[7]}}, byte_v};
         (a_f3 == F3_LH):  ld_val = {{16{half_v[15]}}, half_v};
         (a_f3 == F3_LW):  ld_val = rd_word;
         (a_f3 == F3_LBU): ld_val = {24'h0, byte_v};
         (a_f3 == F3_LHU): ld_val = {16'h0, half_v};
         default:          ld_val = '0;
      endcase
   end

endmodule
